avg_iir_sched: RTL
==================

Name: avg_iir_sched

Overview:
- Time-multiplexes one shared avg_iir datapath across N_CH audio channels.
- Each channel has a one-deep sample holding register and a stored filter state y[n]; per-channel smoothing shift alpha[n] is held in a config register.
- Round-robin arbitration picks a pending channel, issues (x, y_prev, alpha) to the datapath, waits for the result, writes it back and emits it with its channel ID.
- Sits between the I2S channel demux and the downstream mixer.

Parameters:
- N_CH, 8, number of channels; power of 2, 2..32.
- DATA_W, 24, sample width, signed two's complement.
- ACC_W, 32, filter state width, signed; ACC_W >= DATA_W.
- ALPHA_W, 5, width of the per-channel shift amount.
- CH_W, $clog2(N_CH), channel ID width (derived, not overridable).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_ch_valid  in  N_CH  per-channel sample valid.
- o_ch_ready  out  N_CH  per-channel ready; bit n = !pend[n].
- i_ch_data  in  N_CH*DATA_W  packed samples; channel n at [n*DATA_W +: DATA_W].
- i_cfg_we  in  1  config write strobe.
- i_cfg_ch  in  CH_W  config target channel.
- i_cfg_alpha  in  ALPHA_W  new alpha.
- i_cfg_flush  in  1  with i_cfg_we: also clear y[i_cfg_ch] to 0.
- o_dp_valid  out  1  datapath issue valid.
- i_dp_ready  in  1  datapath accepts issue.
- o_dp_x  out  ACC_W  sign-extended sample.
- o_dp_y  out  ACC_W  previous state.
- o_dp_alpha  out  ALPHA_W  shift for this channel.
- i_dp_valid  in  1  datapath result valid.
- i_dp_y  in  ACC_W  new state y' = y + ((x - y) >>> alpha).
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream ready.
- o_data  out  ACC_W  filtered result.
- o_ch  out  CH_W  channel of o_data.
- o_busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async assert, sync deassert internally):
  - pend = 0, all y = 0, all alpha = 4, rr pointer = 0, FSM = IDLE.
  - o_valid = 0, o_dp_valid = 0, o_busy = 0, o_ch = 0, o_data = 0, o_dp_* = 0, o_ch_ready = all 1.
- Input capture: on i_ch_valid[n] && o_ch_ready[n], latch the sample and set pend[n] in the same edge. Each channel is independent; any number of channels can load in one cycle.
- Arbitration (IDLE): if any pend bit is set, grant the first set bit at or after the rr pointer, wrapping modulo N_CH. Set rr = grant+1 (wrapping). Go to ISSUE.
- ISSUE:
  - Drive o_dp_valid = 1 with x, y[grant] and alpha[grant], all held stable until i_dp_ready.
  - On the handshake: clear pend[grant] (o_ch_ready[grant] rises the next cycle), go to WAIT.
- WAIT: on i_dp_valid, write y[grant] = i_dp_y, load o_data/o_ch, go to OUT. Datapath latency is arbitrary, at least 1 cycle. i_dp_valid seen outside WAIT is ignored.
- OUT: hold o_valid = 1 with stable data until i_ready, then go to IDLE.
  - Minimum cycle count per sample: IDLE 1 + ISSUE 1 + WAIT L + OUT 1.
- Config write:
  - Takes effect on the next edge.
  - If it targets the granted channel while in ISSUE or WAIT, the write is deferred one cycle past the WAIT writeback, so the flush wins over the result.
  - Alpha values above ACC_W-1 saturate to ACC_W-1.
- A sample arriving on a channel while that channel is in flight is accepted once pend clears, and is processed in a later round.
- Sign extension: o_dp_x = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x}.
- Reset mid-operation: abandon the in-flight op, drop all pending samples, y is not written.

Optional Feature:
- Macro: AVG_IIR_SCHED_PRIO0_EN.
- Defined: channel 0 has strict priority. When pend[0] is set in IDLE, channel 0 is granted regardless of rr, and rr is not updated. The other channels round-robin among themselves.
- Undefined: pure round-robin over all channels.

Test Plan:
- Reset, then alpha=4 on ch 2 and x=0x100000 -> o_dp_y=0, o_dp_x=0x00100000. Model returns 0x10000 -> o_data=0x00010000, o_ch=2, and y[2] is used on the next ch2 issue.
- All 8 channels pending at once, rr=0, i_ready held 1, DP latency 1 -> o_ch order 0,1,...,7; rr wraps to 0; each o_ch_ready bit rises one cycle after its issue handshake.
- Negative sample x=0x800000 with DATA_W=24 -> o_dp_x=0xFF800000.
- Backpressure: i_ready=0 for 10 cycles in OUT -> o_valid, o_data and o_ch stable; no new issue; afterwards the next channel proceeds.
- Flush on ch 3 written during WAIT -> y[3]=0 after writeback; the emitted o_data still equals i_dp_y.
- Assert i_rst_n=0 during WAIT -> all outputs at reset values immediately, pend=0, y unchanged at 0. With AVG_IIR_SCHED_PRIO0_EN, ch 0 and ch 5 pending with rr=5 -> ch 0 is granted first.

Source files
------------

// File: rtl/avg_iir_sched_if.sv
// Signal bundle for avg_iir_sched: per-channel sample inputs, config port,
// shared datapath issue/result handshake and the filtered output stream.
interface avg_iir_sched_if #(
  parameter int N_CH    = 8,
  parameter int DATA_W  = 24,
  parameter int ACC_W   = 32,
  parameter int ALPHA_W = 5
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]        i_ch_valid;
  logic [N_CH-1:0]        o_ch_ready;
  logic [N_CH*DATA_W-1:0] i_ch_data;
  logic                   i_cfg_we;
  logic [CH_W-1:0]        i_cfg_ch;
  logic [ALPHA_W-1:0]     i_cfg_alpha;
  logic                   i_cfg_flush;
  logic                   o_dp_valid;
  logic                   i_dp_ready;
  logic [ACC_W-1:0]       o_dp_x;
  logic [ACC_W-1:0]       o_dp_y;
  logic [ALPHA_W-1:0]     o_dp_alpha;
  logic                   i_dp_valid;
  logic [ACC_W-1:0]       i_dp_y;
  logic                   o_valid;
  logic                   i_ready;
  logic [ACC_W-1:0]       o_data;
  logic [CH_W-1:0]        o_ch;
  logic                   o_busy;

  modport slave (
    input  i_ch_valid, i_ch_data, i_cfg_we, i_cfg_ch, i_cfg_alpha, i_cfg_flush,
           i_dp_ready, i_dp_valid, i_dp_y, i_ready,
    output o_ch_ready, o_dp_valid, o_dp_x, o_dp_y, o_dp_alpha,
           o_valid, o_data, o_ch, o_busy
  );

  modport master (
    output i_ch_valid, i_ch_data, i_cfg_we, i_cfg_ch, i_cfg_alpha, i_cfg_flush,
           i_dp_ready, i_dp_valid, i_dp_y, i_ready,
    input  o_ch_ready, o_dp_valid, o_dp_x, o_dp_y, o_dp_alpha,
           o_valid, o_data, o_ch, o_busy
  );
endinterface

// File: rtl/avg_iir_sched.sv
// Round-robin scheduler sharing one avg_iir datapath across N_CH channels.
// Define AVG_IIR_SCHED_PRIO0_EN to give channel 0 strict priority.
module avg_iir_sched #(
  parameter int N_CH    = 8,
  parameter int DATA_W  = 24,
  parameter int ACC_W   = 32,
  parameter int ALPHA_W = 5
) (
  input logic            i_clk,
  input logic            i_rst_n,
  avg_iir_sched_if.slave bus
);
  localparam int CH_W = $clog2(N_CH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  logic [1:0] rst_q;
  logic       rst_n_int;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_q <= '0;
    else          rst_q <= {rst_q[0], 1'b1};
  end
  assign rst_n_int = rst_q[1];

  state_t              state;
  logic [N_CH-1:0]     pend;
  logic [DATA_W-1:0]   x_mem [N_CH];
  logic [ACC_W-1:0]    y_mem [N_CH];
  logic [ALPHA_W-1:0]  a_mem [N_CH];
  logic [CH_W-1:0]     rr, grant;
  logic [CH_W-1:0]     arb_idx, cand, rr_next;
  logic                arb_found;
  logic                def_valid, def_flush;
  logic [CH_W-1:0]     def_ch;
  logic [ALPHA_W-1:0]  def_alpha;
  logic [ALPHA_W-1:0]  cfg_alpha_sat;
  logic                cfg_hit_busy;
  logic                dp_valid_q, out_valid_q;
  logic [ACC_W-1:0]    dp_x_q, dp_y_q, out_data_q;
  logic [ALPHA_W-1:0]  dp_alpha_q;
  logic [CH_W-1:0]     out_ch_q;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = rr + CH_W'(i);
      if (!arb_found && pend[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
    rr_next = arb_idx + CH_W'(1);
`ifdef AVG_IIR_SCHED_PRIO0_EN
    if (pend[0]) begin
      arb_found = 1'b1;
      arb_idx   = '0;
      rr_next   = rr;
    end
`endif
  end

  always_comb begin
    cfg_alpha_sat = bus.i_cfg_alpha;
    if (int'(bus.i_cfg_alpha) > ACC_W - 1) cfg_alpha_sat = ALPHA_W'(ACC_W - 1);
  end

  assign cfg_hit_busy = (state == S_ISSUE || state == S_WAIT) && (bus.i_cfg_ch == grant);

  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state       <= S_IDLE;
      pend        <= '0;
      rr          <= '0;
      grant       <= '0;
      def_valid   <= 1'b0;
      def_flush   <= 1'b0;
      def_ch      <= '0;
      def_alpha   <= '0;
      dp_valid_q  <= 1'b0;
      dp_x_q      <= '0;
      dp_y_q      <= '0;
      dp_alpha_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
        x_mem[CH_W'(i)] <= '0;
        y_mem[CH_W'(i)] <= '0;
        a_mem[CH_W'(i)] <= ALPHA_W'(4);
      end
    end else begin
      for (int unsigned n = 0; n < N_CH; n++) begin
        if (bus.i_ch_valid[CH_W'(n)] && !pend[CH_W'(n)]) begin
          x_mem[CH_W'(n)] <= bus.i_ch_data[n*DATA_W +: DATA_W];
          pend[CH_W'(n)]  <= 1'b1;
        end
      end

      case (state)
        S_IDLE: if (arb_found) begin
          grant      <= arb_idx;
          rr         <= rr_next;
          dp_valid_q <= 1'b1;
          // size cast of a signed value replicates the sign bit
          dp_x_q     <= ACC_W'(signed'(x_mem[arb_idx]));
          dp_y_q     <= y_mem[arb_idx];
          dp_alpha_q <= a_mem[arb_idx];
          state      <= S_ISSUE;
        end
        S_ISSUE: if (bus.i_dp_ready) begin
          dp_valid_q  <= 1'b0;
          pend[grant] <= 1'b0;
          state       <= S_WAIT;
        end
        S_WAIT: if (bus.i_dp_valid) begin
          y_mem[grant] <= bus.i_dp_y;
          out_data_q   <= bus.i_dp_y;
          out_ch_q     <= grant;
          out_valid_q  <= 1'b1;
          state        <= S_OUT;
        end
        S_OUT: if (bus.i_ready) begin
          out_valid_q <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Writes to the in-flight channel land one edge after its writeback,
      // so a flush overrides the result; a fresh write in the same edge wins.
      if (def_valid && state == S_OUT) begin
        a_mem[def_ch] <= def_alpha;
        if (def_flush) y_mem[def_ch] <= '0;
        def_valid <= 1'b0;
        def_flush <= 1'b0;
      end

      if (bus.i_cfg_we) begin
        if (cfg_hit_busy) begin
          def_valid <= 1'b1;
          def_ch    <= bus.i_cfg_ch;
          def_alpha <= cfg_alpha_sat;
          def_flush <= (def_valid && def_flush) || bus.i_cfg_flush;
        end else begin
          a_mem[bus.i_cfg_ch] <= cfg_alpha_sat;
          if (bus.i_cfg_flush) y_mem[bus.i_cfg_ch] <= '0;
        end
      end
    end
  end

  assign bus.o_ch_ready = ~pend;
  assign bus.o_dp_valid = dp_valid_q;
  assign bus.o_dp_x     = dp_x_q;
  assign bus.o_dp_y     = dp_y_q;
  assign bus.o_dp_alpha = dp_alpha_q;
  assign bus.o_valid    = out_valid_q;
  assign bus.o_data     = out_data_q;
  assign bus.o_ch       = out_ch_q;
  assign bus.o_busy     = (state != S_IDLE);
endmodule
